// File: rtl/servo_pwm_bank.sv
// ============================================================================
// servo_pwm_bank
// ----------------------------------------------------------------------------
// Purpose:
//   Six-channel hobby-servo PWM generator. It takes the six 7-bit servo
//   positions from the register file and drives one pulse per channel per
//   frame. Positions and the output enable are captured only at frame
//   boundaries, so processor writes never truncate or stretch a pulse in
//   flight.
//
// Ports:
//   i_clock        in   1  system clock, all logic on the rising edge
//   i_ctrl_reset   in   1  synchronous, active-high reset
//   i_enable       in   1  output enable, captured at frame boundaries only
//   i_servo0..5    in   7  unsigned position per channel
//   o_pwm          out  6  o_pwm[n] drives servo n (registered)
//   o_frame_start  out  1  one-cycle pulse on the first cycle of each frame
//                          (registered)
// ============================================================================
module servo_pwm_bank #(
    parameter int PRESCALE    = 500,
    parameter int FRAME_TICKS = 2000,
    parameter int BASE_TICKS  = 100,
    parameter int MAX_POS     = 100
) (
    input  logic       i_clock,
    input  logic       i_ctrl_reset,
    input  logic       i_enable,
    input  logic [6:0] i_servo0,
    input  logic [6:0] i_servo1,
    input  logic [6:0] i_servo2,
    input  logic [6:0] i_servo3,
    input  logic [6:0] i_servo4,
    input  logic [6:0] i_servo5,
    output logic [5:0] o_pwm,
    output logic       o_frame_start
);

    localparam int PW = $clog2(PRESCALE);
    localparam int FW = $clog2(FRAME_TICKS);
    // Common width for comparing the frame counter against a pulse width.
    localparam int CW = (FW > 8) ? FW : 8;

    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [6:0]    MAX_POS_V  = 7'(MAX_POS);
    localparam logic [7:0]    BASE_V     = 8'(BASE_TICKS);

    logic [PW-1:0] r_preCnt;
    logic [FW-1:0] r_frameCnt;
    logic [6:0]    r_shadow [6];
    logic          r_enShadow;
    logic [5:0]    r_pwm;
    logic          r_frameStart;

    logic [6:0]    w_servo      [6];
    logic [6:0]    w_shadowNext [6];
    logic [7:0]    w_width      [6];
    logic          w_tick;
    logic          w_boundary;
    logic [PW-1:0] w_preNext;
    logic [FW-1:0] w_frameNext;
    logic          w_enNext;
    logic [5:0]    w_pwmNext;

    assign w_servo[0] = i_servo0;
    assign w_servo[1] = i_servo1;
    assign w_servo[2] = i_servo2;
    assign w_servo[3] = i_servo3;
    assign w_servo[4] = i_servo4;
    assign w_servo[5] = i_servo5;

    // A tick ends each prescaler period; the last tick of the frame is the
    // boundary where everything is re-latched.
    assign w_tick     = (r_preCnt == PRE_LAST);
    assign w_boundary = w_tick && (r_frameCnt == FRAME_LAST);

    // Next-state values for counters and shadows. The PWM register is driven
    // from these next-state values so that on the boundary edge the output
    // rises together with frame_start, using the freshly latched position
    // and enable. A channel stays high while the frame counter is below its
    // width in ticks, which is exactly width*PRESCALE cycles.
    always_comb begin
        w_preNext   = w_tick ? '0 : r_preCnt + PW'(1);
        w_frameNext = r_frameCnt;
        if (w_boundary) begin
            w_frameNext = '0;
        end else if (w_tick) begin
            w_frameNext = r_frameCnt + FW'(1);
        end
        w_enNext  = w_boundary ? i_enable : r_enShadow;
        w_pwmNext = '0;
        for (int n = 0; n < 6; n++) begin
            w_shadowNext[n] = r_shadow[n];
            if (w_boundary) begin
                w_shadowNext[n] = (w_servo[n] > MAX_POS_V) ? MAX_POS_V : w_servo[n];
            end
            w_width[n]   = BASE_V + {1'b0, w_shadowNext[n]};
            w_pwmNext[n] = w_enNext && (CW'(w_frameNext) < CW'(w_width[n]));
        end
    end

    // State register. Reset wins over everything, including a pulse in
    // progress, and drops the outputs on the following cycle.
    always_ff @(posedge i_clock) begin
        if (i_ctrl_reset) begin
            r_preCnt     <= '0;
            r_frameCnt   <= '0;
            r_enShadow   <= 1'b0;
            r_pwm        <= '0;
            r_frameStart <= 1'b0;
            for (int n = 0; n < 6; n++) begin
                r_shadow[n] <= '0;
            end
        end else begin
            r_preCnt     <= w_preNext;
            r_frameCnt   <= w_frameNext;
            r_enShadow   <= w_enNext;
            r_pwm        <= w_pwmNext;
            r_frameStart <= w_boundary;
            for (int n = 0; n < 6; n++) begin
                r_shadow[n] <= w_shadowNext[n];
            end
        end
    end

    assign o_pwm         = r_pwm;
    assign o_frame_start = r_frameStart;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// ============================================================================
// tb_servo_pwm_bank
// ----------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for servo_pwm_bank with small parameters
//   (frame = 200 cycles). A frame-level reference model tracks the number of
//   edges since reset, latches enable and pulse widths at each frame
//   boundary, and predicts o_pwm / o_frame_start every cycle.
// ============================================================================
module tb_servo_pwm_bank;

    localparam int PRESCALE    = 4;
    localparam int FRAME_TICKS = 50;
    localparam int BASE_TICKS  = 5;
    localparam int MAX_POS     = 20;
    localparam int FP          = PRESCALE * FRAME_TICKS;

    logic       clock = 1'b0;
    logic       ctrlReset = 1'b1;
    logic       enable = 1'b0;
    logic [6:0] servo [6];
    logic [5:0] pwm;
    logic       frameStart;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: edges since the last reset edge, plus the
    // enable and pulse widths (in cycles) captured at the last boundary.
    int t = 0;
    bit mEn = 1'b0;
    int mWidth [6];

    servo_pwm_bank #(
        .PRESCALE   (PRESCALE),
        .FRAME_TICKS(FRAME_TICKS),
        .BASE_TICKS (BASE_TICKS),
        .MAX_POS    (MAX_POS)
    ) dut (
        .i_clock      (clock),
        .i_ctrl_reset (ctrlReset),
        .i_enable     (enable),
        .i_servo0     (servo[0]),
        .i_servo1     (servo[1]),
        .i_servo2     (servo[2]),
        .i_servo3     (servo[3]),
        .i_servo4     (servo[4]),
        .i_servo5     (servo[5]),
        .o_pwm        (pwm),
        .o_frame_start(frameStart)
    );

    always #5 clock = ~clock;

    // Frame-level model: inputs only change on the falling edge, so sampling
    // them here on the rising edge sees the same values the DUT sees.
    always @(posedge clock) begin
        if (ctrlReset) begin
            t   = 0;
            mEn = 1'b0;
            for (int n = 0; n < 6; n++) mWidth[n] = BASE_TICKS * PRESCALE;
        end else begin
            t++;
            if (t % FP == 0) begin
                mEn = enable;
                for (int n = 0; n < 6; n++) begin
                    int pos;
                    pos = int'(servo[n]);
                    if (pos > MAX_POS) pos = MAX_POS;
                    mWidth[n] = (BASE_TICKS + pos) * PRESCALE;
                end
            end
        end
    end

    // Compare both outputs against the model for the current cycle.
    task automatic checkOutput();
        int         phase;
        logic       expFs;
        logic [5:0] expPwm;
        phase = t % FP;
        expFs = (t > 0) && (phase == 0);
        for (int n = 0; n < 6; n++) begin
            expPwm[n] = mEn && (phase < mWidth[n]);
        end
        assertCount++;
        assert (frameStart === expFs) else begin
            failCount++;
            $error("[TB] FAIL frame_start t=%0d observed=%b expected=%b", t, frameStart, expFs);
        end
        assertCount++;
        assert (pwm === expPwm) else begin
            failCount++;
            $error("[TB] FAIL pwm t=%0d observed=%b expected=%b", t, pwm, expPwm);
        end
    endtask

    task automatic runCycles(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clock);
            checkOutput();
        end
    endtask

    // Advance until the model is at the requested cycle of the frame.
    task automatic runToPhase(input int ph);
        int guard;
        guard = 0;
        while ((t % FP) != ph && guard <= FP) begin
            runCycles(1);
            guard++;
        end
        if ((t % FP) != ph) begin
            assertCount++;
            failCount++;
            $error("[TB] FAIL phase_wait observed=%0d expected=%0d", t % FP, ph);
        end
    endtask

    task automatic applyStimulus(input logic en, input int s0, input int s1,
                                 input int s2, input int s3, input int s4,
                                 input int s5);
        enable   = en;
        servo[0] = 7'(s0);
        servo[1] = 7'(s1);
        servo[2] = 7'(s2);
        servo[3] = 7'(s3);
        servo[4] = 7'(s4);
        servo[5] = 7'(s5);
    endtask

    task automatic pulseReset();
        ctrlReset = 1'b1;
        runCycles(1);
        ctrlReset = 1'b0;
    endtask

    initial begin
        for (int n = 0; n < 6; n++) servo[n] = '0;

        // Reset, enable with servo0=10; frame_start every 200 cycles and a
        // 60-cycle pulse on channel 0.
        @(negedge clock);
        applyStimulus(1'b1, 10, $urandom_range(0, 127), $urandom_range(0, 127),
                      $urandom_range(0, 127), $urandom_range(0, 127),
                      $urandom_range(0, 127));
        pulseReset();
        runCycles(2 * FP + 10);

        // Clamped and minimum positions on channels 1 and 2.
        servo[1] = 7'd127;
        servo[2] = 7'd0;
        runCycles(2 * FP);

        // Mid-pulse position change only affects the next frame.
        runToPhase(30);
        servo[0] = 7'd3;
        runCycles(2 * FP);

        // Enable drop mid-pulse, then a mid-frame raise.
        runToPhase(10);
        enable = 1'b0;
        runCycles(2 * FP);
        runToPhase(100);
        enable = 1'b1;
        runCycles(FP + FP / 2);

        // Reset in the middle of a pulse.
        runToPhase(20);
        pulseReset();
        runCycles(FP + 20);

        // Six distinct positions spanning the legal range.
        applyStimulus(1'b1, 0, 20, 7, 13, 3, 17);
        runCycles(2 * FP);

        // Random positions and enables, changed at random points in a frame.
        for (int k = 0; k < 6; k++) begin
            runToPhase($urandom_range(0, FP - 1));
            applyStimulus(1'($urandom_range(0, 3) != 0),
                          $urandom_range(0, 127), $urandom_range(0, 30),
                          $urandom_range(0, 127), $urandom_range(0, 25),
                          $urandom_range(0, 127), $urandom_range(0, 21));
            runCycles(FP + $urandom_range(0, 50));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
